// File: rtl/mnist_nn_pkg.sv
// Shared constants and payload types for the MNIST network datapath.
package mnist_nn_pkg;

  localparam int unsigned NUM_CHANNELS = 8;
  localparam int unsigned POOL1_OUT_W  = 13;
  localparam int unsigned POOL1_OUT_H  = 13;

  // One pooled pixel across all channels, channel 1 in bit 0
  typedef logic [NUM_CHANNELS-1:0] pixel_word_t;

endpackage

// File: rtl/fmap_stream_buffer_if.sv
// Pooled feature-map input stream and dense replay stream.
interface fmap_stream_buffer_if;

  logic valid_in;
  logic pixel_in_1;
  logic pixel_in_2;
  logic pixel_in_3;
  logic pixel_in_4;
  logic pixel_in_5;
  logic pixel_in_6;
  logic pixel_in_7;
  logic pixel_in_8;
  logic out_ready;
  logic pixel_out_1;
  logic pixel_out_2;
  logic pixel_out_3;
  logic pixel_out_4;
  logic pixel_out_5;
  logic pixel_out_6;
  logic pixel_out_7;
  logic pixel_out_8;
  logic valid_out;
  logic frame_start;
  logic frame_end;
  logic overflow;

  // Producer / consumer side
  modport master (
    output valid_in, pixel_in_1, pixel_in_2, pixel_in_3, pixel_in_4,
           pixel_in_5, pixel_in_6, pixel_in_7, pixel_in_8, out_ready,
    input  pixel_out_1, pixel_out_2, pixel_out_3, pixel_out_4,
           pixel_out_5, pixel_out_6, pixel_out_7, pixel_out_8,
           valid_out, frame_start, frame_end, overflow
  );

  // Buffer side
  modport slave (
    input  valid_in, pixel_in_1, pixel_in_2, pixel_in_3, pixel_in_4,
           pixel_in_5, pixel_in_6, pixel_in_7, pixel_in_8, out_ready,
    output pixel_out_1, pixel_out_2, pixel_out_3, pixel_out_4,
           pixel_out_5, pixel_out_6, pixel_out_7, pixel_out_8,
           valid_out, frame_start, frame_end, overflow
  );

endinterface

// File: rtl/fmap_stream_buffer_bank.sv
// One frame bank: register array, synchronous write, combinational read.
module fmap_bank
  import mnist_nn_pkg::*;
#(
  parameter int unsigned DEPTH = 169,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_word_t   wdata,
  input  logic [AW-1:0] raddr,
  output pixel_word_t   rdata
);

  pixel_word_t mem [DEPTH];

  // Storage write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fmap_stream_buffer.sv
// Ping-pong frame buffer turning sparse pooled pixels into a dense raster stream.
module fmap_stream_buffer
  import mnist_nn_pkg::*;
#(
  parameter int unsigned WIDTH  = POOL1_OUT_W,
  parameter int unsigned HEIGHT = POOL1_OUT_H
) (
  input  logic                clk,
  input  logic                rst_n,
  fmap_stream_buffer_if.slave bus
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LAST  = DEPTH - 1;

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic          overflow_q;
  logic          valid_q;
  logic          frame_start_q;
  logic          frame_end_q;
  pixel_word_t   data_q;

  pixel_word_t   in_word_c;
  pixel_word_t   rd_word_c;
  pixel_word_t   bank_rdata_c [2];
  logic [1:0]    bank_we_c;
  logic [1:0]    full_nxt_c;
  logic          wr_en_c;
  logic          wr_last_c;
  logic          rd_last_c;
  logic          load_c;

  assign in_word_c = {bus.pixel_in_8, bus.pixel_in_7, bus.pixel_in_6, bus.pixel_in_5,
                      bus.pixel_in_4, bus.pixel_in_3, bus.pixel_in_2, bus.pixel_in_1};

  assign wr_en_c   = bus.valid_in & ~full[wr_bank];
  assign wr_last_c = (wr_cnt == AW'(LAST));
  assign rd_last_c = (rd_cnt == AW'(LAST));
  assign load_c    = full[rd_bank] & (~valid_q | bus.out_ready);
  assign bank_we_c = {wr_en_c & wr_bank, wr_en_c & ~wr_bank};
  assign rd_word_c = rd_bank ? bank_rdata_c[1] : bank_rdata_c[0];

  fmap_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (bank_we_c[0]),
    .waddr (wr_cnt),
    .wdata (in_word_c),
    .raddr (rd_cnt),
    .rdata (bank_rdata_c[0])
  );

  fmap_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (bank_we_c[1]),
    .waddr (wr_cnt),
    .wdata (in_word_c),
    .raddr (rd_cnt),
    .rdata (bank_rdata_c[1])
  );

  // Full flags: writer sets its bank, reader frees its bank; never the same bank at once
  always_comb begin
    full_nxt_c = full;
    if (wr_en_c && wr_last_c) full_nxt_c[wr_bank] = 1'b1;
    if (load_c && rd_last_c)  full_nxt_c[rd_bank] = 1'b0;
  end

  // Write pointer, bank select and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.valid_in) begin
      if (!full[wr_bank]) begin
        if (wr_last_c) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= AW'(wr_cnt + 1'b1);
        end
      end else begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Bank occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= full_nxt_c;
  end

  // Output register and read pointer; holds everything while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt        <= '0;
      rd_bank       <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      data_q        <= '0;
    end else if (load_c) begin
      valid_q       <= 1'b1;
      frame_start_q <= (rd_cnt == '0);
      frame_end_q   <= rd_last_c;
      data_q        <= rd_word_c;
      if (rd_last_c) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt  <= AW'(rd_cnt + 1'b1);
      end
    end else if (bus.out_ready) begin
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.overflow    = overflow_q;
  assign bus.pixel_out_1 = data_q[0];
  assign bus.pixel_out_2 = data_q[1];
  assign bus.pixel_out_3 = data_q[2];
  assign bus.pixel_out_4 = data_q[3];
  assign bus.pixel_out_5 = data_q[4];
  assign bus.pixel_out_6 = data_q[5];
  assign bus.pixel_out_7 = data_q[6];
  assign bus.pixel_out_8 = data_q[7];

endmodule
